// File: rtl/useq.sv
// Microcode sequencer: micro-PC, next-address select, NMI edge capture and vector-index substitution.
// Optional build macro USEQ_SYNC_EN adds two-flop synchronizers on nmi and irq.
module useq #(
    parameter int UW = 19
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rdy,
    output logic [8:0]    uaddr,
    input  logic [UW-1:0] uword,
    input  logic [7:0]    DI,
    input  logic          cond,
    input  logic          I,
    input  logic          irq,
    input  logic          nmi,
    output logic [6:0]    op,
    output logic          sync
);

    localparam logic [8:0] RESET_ADDR = 9'h100;
    localparam logic [8:0] INT_ADDR   = 9'h101;
    localparam logic [8:0] FETCH_ADDR = 9'h102;

    localparam logic [1:0] SEQ_NEXT     = 2'b00;
    localparam logic [1:0] SEQ_JUMP     = 2'b01;
    localparam logic [1:0] SEQ_DISPATCH = 2'b10;
    localparam logic [1:0] SEQ_COND     = 2'b11;

    localparam logic [1:0] VEC_NMI = 2'd0;
    localparam logic [1:0] VEC_RST = 2'd1;
    localparam logic [1:0] VEC_BRK = 2'd2;

    logic [8:0] upc, upc_nxt;
    logic [1:0] vec, vec_nxt;
    logic       nmi_pend, nmi_q;
    logic       nmi_in, irq_in;

    logic [6:0] rop;
    logic [1:0] seq;
    logic [8:0] target;
    logic       done;
    logic       nmi_edge, take_nmi, take_irq;

    assign rop    = uword[6:0];
    assign seq    = uword[8:7];
    assign target = uword[17:9];
    assign done   = uword[18];

`ifdef USEQ_SYNC_EN
    logic [1:0] nmi_sync, irq_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nmi_sync <= 2'b00;
            irq_sync <= 2'b00;
        end else begin
            nmi_sync <= {nmi_sync[0], nmi};
            irq_sync <= {irq_sync[0], irq};
        end
    end

    assign nmi_in = nmi_sync[1];
    assign irq_in = irq_sync[1];
`else
    assign nmi_in = nmi;
    assign irq_in = irq;
`endif

    assign nmi_edge = nmi_in & ~nmi_q;
    assign take_nmi = done & nmi_pend;
    assign take_irq = done & ~nmi_pend & irq_in & ~I;

    always_comb begin
        upc_nxt = upc + 9'd1;
        vec_nxt = vec;
        if (done) begin
            if (take_nmi) begin
                upc_nxt = INT_ADDR;
                vec_nxt = VEC_NMI;
            end else if (take_irq) begin
                upc_nxt = INT_ADDR;
                vec_nxt = VEC_BRK;
            end else begin
                upc_nxt = FETCH_ADDR;
            end
        end else begin
            case (seq)
                SEQ_NEXT: upc_nxt = upc + 9'd1;
                SEQ_JUMP: upc_nxt = target;
                SEQ_DISPATCH: begin
                    upc_nxt = {1'b0, DI};
                    vec_nxt = VEC_BRK;
                end
                SEQ_COND: upc_nxt = cond ? target : upc + 9'd1;
                default:  upc_nxt = upc + 9'd1;
            endcase
        end
    end

    // Edge capture runs every cycle; only the clear on NMI entry waits for rdy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upc      <= RESET_ADDR;
            vec      <= VEC_RST;
            nmi_pend <= 1'b0;
            nmi_q    <= 1'b0;
        end else begin
            nmi_q <= nmi_in;
            if (rdy) begin
                upc <= upc_nxt;
                vec <= vec_nxt;
            end
            if (nmi_edge) begin
                nmi_pend <= 1'b1;
            end else if (rdy && take_nmi) begin
                nmi_pend <= 1'b0;
            end
        end
    end

    assign uaddr = upc;
    assign sync  = (seq == SEQ_DISPATCH) & ~done;

    always_comb begin
        op = rop;
        if (rop[3:0] == 4'h8) begin
            op[3:0] = 4'h8 + {2'b00, vec};
        end
    end

endmodule
